booth_mac_accum: RTL
====================

// Module: booth_mac_accum
// PURPOSE
//  Downstream consumer of the Booth multiplier (data_path/control_path pair).
//  - Captures each finished signed product {A,Q} once per rising edge of done.
//  - Sign-extends the product and adds it into a saturating accumulator.
//  - After NUM_TERMS products, presents the sum on a valid/ready output port.
// PARAMETERS
//  W          5   operand width of the multiplier; the product is 2*W bits, two's complement
//  ACC_W     16   accumulator width, signed; required: ACC_W >= 2*W
//  NUM_TERMS  4   products summed per result; range 1..255
// PORTS
//  clk        in   1      rising-edge clock, shared with the multiplier
//  rst        in   1      synchronous, active-high reset
//  done       in   1      multiplier done level; may stay high for many cycles
//  prod_hi    in   W      product upper half (A register)
//  prod_lo    in   W      product lower half (Q register)
//  clear_acc  in   1      synchronous flush: same effect as rst
//  out_ready  in   1      downstream accepts acc_out
//  out_valid  out  1      acc_out holds a completed sum
//  acc_out    out  ACC_W  accumulated signed sum
//  term_cnt   out  8      products accumulated into the current sum
//  sat_flag   out  1      sticky: saturation occurred in the current sum
//  overrun    out  1      sticky: a product was dropped while in HOLD
// BEHAVIOUR
//  Reset/clear (rst or clear_acc high at a clock edge):
//  - acc_out=0, term_cnt=0, out_valid=0, sat_flag=0, overrun=0, done_d=0, state=ACC.
//  - Takes priority over every other event in the same cycle.
//  - A capture in that cycle is discarded; it is not counted and does not set overrun.
//  Capture and accumulation:
//  - cap = done & ~done_d, where done_d is done registered once per clock.
//  - When done is already high at the first edge after reset, that edge counts as a capture.
//  - The product is $signed({prod_hi,prod_lo}), sign-extended to ACC_W+1 bits and added to acc.
//  - Saturation: a sum > 2^(ACC_W-1)-1 clamps to max; a sum < -2^(ACC_W-1) clamps to min.
//    Either clamp sets sat_flag.
//  - Latency: with cap at edge n, acc_out and term_cnt show the update after edge n
//    (one register stage).
//  FSM, two states:
//  - ACC:
//    - On cap, accumulate and increment term_cnt.
//    - When this cap brings term_cnt to NUM_TERMS, go to HOLD and set out_valid=1
//      at the same edge.
//  - HOLD:
//    - out_valid=1. acc_out, term_cnt and sat_flag are frozen.
//    - A cap with no accept in the same cycle: product dropped, overrun=1.
//    - On out_valid & out_ready: go to ACC, out_valid=0, sat_flag=0, overrun=0.
//      acc_out=0 and term_cnt=0, except as in the next item.
//    - Accept and cap in the same cycle: the product becomes the first term of the new sum.
//      acc_out=sext(product), term_cnt=1, overrun stays 0.
//      With NUM_TERMS=1, stay in HOLD: out_valid=1 with the new value.
//  - out_ready is ignored while out_valid=0.
//  - acc_out is stable while out_valid=1 and out_ready=0.
//  - Reset mid-sum or mid-HOLD: the partial or pending result is lost, with no output pulse.
// TESTING
//  T1: W=5, dinA=-10, dinQ=13 (product -130 = 10'b1101111110) four times, NUM_TERMS=4,
//      out_ready=1
//      -> out_valid=1 one cycle after the 4th done edge, acc_out=16'hFDF8 (-520), sat_flag=0.
//  T2: done held high 6 cycles, NUM_TERMS=4 -> term_cnt=1 only; lowering and raising
//      done -> term_cnt=2.
//  T3: ACC_W=12, NUM_TERMS=8, product (-16)*(-16)=256 eight times
//      -> acc_out=12'h7FF (2047), sat_flag=1.
//  T4: NUM_TERMS=4 completed, out_ready=0, 5th done edge -> overrun=1, acc_out still
//      -520; then out_ready=1 -> out_valid=0, acc_out=0, overrun=0.
//  T5: in HOLD, 5th done edge (product -130) in the same cycle as out_ready=1
//      -> out_valid=0, term_cnt=1, acc_out=-130, overrun=0.
//  T6: rst high for one cycle after 2 terms accumulated
//      -> all outputs 0 next cycle; then 4 new products give a correct sum from zero.

Source files
------------

// File: rtl/booth_mac_accum.sv
// booth_mac_accum
//   Consumer of a Booth multiplier. It captures one signed product {prod_hi,prod_lo}
//   on each rising edge of done and adds it into a saturating accumulator. After
//   NUM_TERMS products it holds the sum on a valid/ready output port.
// Ports:
//   clk        rising-edge clock (shared with the multiplier)
//   rst        synchronous active-high reset
//   done       multiplier done level; only its rising edge is used
//   prod_hi    product upper half (A register), W bits
//   prod_lo    product lower half (Q register), W bits
//   clear_acc  synchronous flush, same effect as rst
//   out_ready  downstream accepts acc_out
//   out_valid  acc_out holds a completed sum
//   acc_out    accumulated signed sum, ACC_W bits
//   term_cnt   products accumulated into the current sum
//   sat_flag   sticky: saturation occurred in the current sum
//   overrun    sticky: a product was dropped while holding a result
module booth_mac_accum #(
  parameter int W         = 5,
  parameter int ACC_W     = 16,
  parameter int NUM_TERMS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             done,
  input  logic [W-1:0]     prod_hi,
  input  logic [W-1:0]     prod_lo,
  input  logic             clear_acc,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [ACC_W-1:0] acc_out,
  output logic [7:0]       term_cnt,
  output logic             sat_flag,
  output logic             overrun
);

  typedef enum logic {S_ACC = 1'b0, S_HOLD = 1'b1} state_t;

  localparam logic [7:0] LP_NUM_TERMS = 8'(NUM_TERMS);

  state_t           r_state, w_state_next;
  logic             r_done_d;
  logic [ACC_W-1:0] r_acc, w_acc_next;
  logic [7:0]       r_cnt, w_cnt_next;
  logic             r_sat, w_sat_next;
  logic             r_ovr, w_ovr_next;

  logic             w_cap;
  logic             w_accept;
  logic [2*W-1:0]   w_prod;
  logic [ACC_W:0]   w_prod_ext;
  logic [ACC_W:0]   w_sum;
  logic             w_pos_ovf;
  logic             w_neg_ovf;
  logic [ACC_W-1:0] w_sum_sat;
  logic [7:0]       w_cnt_inc;

  assign w_cap    = done & ~r_done_d;
  assign w_accept = (r_state == S_HOLD) & out_ready;
  assign w_prod   = {prod_hi, prod_lo};

  // One guard bit above ACC_W is enough: |product| <= 2^(ACC_W-1).
  assign w_prod_ext = {{(ACC_W + 1 - 2*W){w_prod[2*W-1]}}, w_prod};
  assign w_sum      = {r_acc[ACC_W-1], r_acc} + w_prod_ext;

  // Guard bit and top result bit disagree -> the sum left the ACC_W range.
  assign w_pos_ovf = ~w_sum[ACC_W] &  w_sum[ACC_W-1];
  assign w_neg_ovf =  w_sum[ACC_W] & ~w_sum[ACC_W-1];

  always_comb begin
    w_sum_sat = w_sum[ACC_W-1:0];
    if (w_pos_ovf)
      w_sum_sat = {1'b0, {(ACC_W-1){1'b1}}};
    else if (w_neg_ovf)
      w_sum_sat = {1'b1, {(ACC_W-1){1'b0}}};
  end

  assign w_cnt_inc = r_cnt + 8'd1;

  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_cnt_next   = r_cnt;
    w_sat_next   = r_sat;
    w_ovr_next   = r_ovr;
    case (r_state)
      S_ACC: begin
        if (w_cap) begin
          w_acc_next = w_sum_sat;
          w_cnt_next = w_cnt_inc;
          w_sat_next = r_sat | w_pos_ovf | w_neg_ovf;
          if (w_cnt_inc == LP_NUM_TERMS)
            w_state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_accept) begin
          w_sat_next = 1'b0;
          w_ovr_next = 1'b0;
          if (w_cap) begin
            // The product arriving with the accept starts the next sum; a
            // single product can never saturate since ACC_W >= 2*W.
            w_acc_next   = w_prod_ext[ACC_W-1:0];
            w_cnt_next   = 8'd1;
            w_state_next = (LP_NUM_TERMS == 8'd1) ? S_HOLD : S_ACC;
          end else begin
            w_acc_next   = '0;
            w_cnt_next   = 8'd0;
            w_state_next = S_ACC;
          end
        end else if (w_cap) begin
          w_ovr_next = 1'b1;
        end
      end
      default: w_state_next = S_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clear_acc) begin
      r_state  <= S_ACC;
      r_done_d <= 1'b0;
      r_acc    <= '0;
      r_cnt    <= 8'd0;
      r_sat    <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_done_d <= done;
      r_acc    <= w_acc_next;
      r_cnt    <= w_cnt_next;
      r_sat    <= w_sat_next;
      r_ovr    <= w_ovr_next;
    end
  end

  assign out_valid = (r_state == S_HOLD);
  assign acc_out   = r_acc;
  assign term_cnt  = r_cnt;
  assign sat_flag  = r_sat;
  assign overrun   = r_ovr;

endmodule
